// File: rtl/terrain_column_renderer.sv
// terrain_column_renderer: walks the screen-height RAM each frame and streams column-major sky/ground pixels.
// Optional build macro RENDER_SURFACE_EN marks the top ground pixel of each column with SURF_COL.
module terrain_column_renderer #(
    parameter int          SCR_W    = 160,
    parameter int          SCR_H    = 120,
    parameter logic [2:0]  SKY_COL  = 3'b001,
    parameter logic [2:0]  GND_COL  = 3'b010,
    parameter logic [2:0]  SURF_COL = 3'b111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [9:0]  ram_addr,
    input  logic [8:0]  ram_q,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, DRAW, FINISH} state_t;

    state_t      state_q, state_d;
    logic [7:0]  col_q, col_d;
    logic [6:0]  row_q, row_d;
    logic [8:0]  h_q, h_d;
    logic [9:0]  ram_addr_q, ram_addr_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [8:0]  thresh;
    logic        ground;
    logic        surface;
    logic [2:0]  pix_col;

    always_comb begin
        // h is saturated to SCR_H, so the threshold never wraps
        thresh = 9'(SCR_H) - h_q;
        ground = {2'b00, row_q} >= thresh;
`ifdef RENDER_SURFACE_EN
        surface = ({2'b00, row_q} == thresh) && (h_q != 9'd0);
`else
        surface = 1'b0;
`endif
        pix_col = surface ? SURF_COL : (ground ? GND_COL : SKY_COL);
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        h_d        = h_q;
        ram_addr_d = ram_addr_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = plot_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                plot_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    col_d      = 8'd0;
                    ram_addr_d = 10'd0;
                    busy_d     = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                plot_d  = 1'b0;
                state_d = LATCH;
            end
            LATCH: begin
                h_d     = (ram_q >= 9'(SCR_H)) ? 9'(SCR_H) : ram_q;
                row_d   = 7'd0;
                y_d     = 7'd0;
                state_d = DRAW;
            end
            DRAW: begin
                plot_d   = 1'b1;
                x_d      = col_q;
                y_d      = row_q;
                colour_d = pix_col;
                if (row_q == 7'(SCR_H - 1)) begin
                    if (col_q == 8'(SCR_W - 1)) begin
                        state_d = FINISH;
                    end else begin
                        col_d      = col_q + 8'd1;
                        ram_addr_d = {2'b00, col_q + 8'd1};
                        state_d    = FETCH;
                    end
                end else begin
                    row_d = row_q + 7'd1;
                end
            end
            FINISH: begin
                plot_d  = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            col_q      <= 8'd0;
            row_q      <= 7'd0;
            h_q        <= 9'd0;
            ram_addr_q <= 10'd0;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            colour_q   <= 3'd0;
            plot_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            h_q        <= h_d;
            ram_addr_q <= ram_addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign x        = x_q;
    assign y        = y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_terrain_column_renderer.sv
// tb_terrain_column_renderer: directed frames against a synchronous RAM model, per-column pixel tallies.
module tb_terrain_column_renderer;
    localparam int SKY  = 1;
    localparam int GND  = 2;
    localparam int SURF = 7;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  ram_addr;
    logic [8:0]  ram_q = 9'd0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    logic [8:0]  mem [1024];
    logic        clr_req = 1'b0;

    int errors = 0;
    int checks = 0;
    int pix, gtot, badcol, order_err, done_cnt, max_addr, ex, ey;
    int gcnt [160];
    int first [160];
    int surf [160];

    terrain_column_renderer dut (
        .clock(clock), .reset(reset), .start(start), .ram_addr(ram_addr), .ram_q(ram_q),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #10 clock = ~clock;

    always @(posedge clock) ram_q <= mem[ram_addr];

    always @(negedge clock) begin
        if (clr_req) begin
            pix = 0; gtot = 0; badcol = 0; order_err = 0; done_cnt = 0; max_addr = 0; ex = 0; ey = 0;
            for (int i = 0; i < 160; i++) begin
                gcnt[i] = 0; first[i] = -1; surf[i] = -1;
            end
        end else begin
            if (done) done_cnt++;
            if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
            if (plot) begin
                pix++;
                if (int'(x) != ex || int'(y) != ey) order_err++;
                if (ey == 119) begin ey = 0; ex++; end else ey++;
                if (int'(colour) != SKY && int'(colour) != GND && int'(colour) != SURF) badcol++;
`ifndef RENDER_SURFACE_EN
                if (int'(colour) == SURF) badcol++;
`endif
                if (x < 8'd160 && (int'(colour) == GND || int'(colour) == SURF)) begin
                    gtot++;
                    gcnt[x]++;
                    if (first[x] < 0) first[x] = int'(y);
                    if (int'(colour) == SURF) surf[x] = int'(y);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        clr_req = 1'b1;
        @(posedge clock);
        @(posedge clock);
        clr_req = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 25000) begin
            @(posedge clock);
            #1 cyc++;
        end
        if (!done) chk("done_timeout", cyc, -1);
    endtask

    typedef struct {
        int col;
        int h;
        int gnd;
        int top;
    } vec_t;

    vec_t vt [9];

    initial begin
        int cyc;
        int n;
        int p0;
        vt[0] = '{0,   511, 120, 0};
        vt[1] = '{5,   30,  30,  90};
        vt[2] = '{159, 1,   1,   119};
        vt[3] = '{10,  120, 120, 0};
        vt[4] = '{11,  119, 119, 1};
        vt[5] = '{12,  121, 120, 0};
        vt[6] = '{20,  60,  60,  60};
        vt[7] = '{1,   0,   0,   -1};
        vt[8] = '{100, 2,   2,   118};
        for (int i = 0; i < 1024; i++) mem[i] = 9'd0;
        reset = 1'b0;
        start = 1'b0;
        clear_stats();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_xyc", int'({x, y, colour}), 0);
        chk("rst_addr", int'(ram_addr), 0);
        reset = 1'b1;

        // all-sky frame and exact frame length
        clear_stats();
        start_pulse();
        chk("busy_after_accept", int'(busy), 1);
        wait_done(cyc);
        chk("done_latency", cyc, 19521);
        chk("busy_at_done", int'(busy), 0);
        repeat (3) @(posedge clock);
        #1;
        chk("t1_pixels", pix, 19200);
        chk("t1_ground", gtot, 0);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_max_addr", max_addr, 159);
        chk("t1_order", order_err, 0);
        chk("t1_badcol", badcol, 0);

        // height table frame
        for (int i = 0; i < 9; i++) mem[vt[i].col] = 9'(vt[i].h);
        mem[160] = 9'd77;
        mem[1023] = 9'd77;
        clear_stats();
        start_pulse();
        wait_done(cyc);
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("col%0d_gnd", vt[i].col), gcnt[vt[i].col], vt[i].gnd);
            chk($sformatf("col%0d_top", vt[i].col), first[vt[i].col], vt[i].top);
`ifdef RENDER_SURFACE_EN
            chk($sformatf("col%0d_surf", vt[i].col), surf[vt[i].col], vt[i].top);
`else
            chk($sformatf("col%0d_surf", vt[i].col), surf[vt[i].col], -1);
`endif
        end
        chk("t2_pixels", pix, 19200);
        chk("t2_ground", gtot, 572);
        chk("t2_max_addr", max_addr, 159);
        chk("t2_order", order_err, 0);
        chk("t2_badcol", badcol, 0);

        // start while busy is ignored
        clear_stats();
        start_pulse();
        repeat (1000) @(posedge clock);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc);
        repeat (5) @(posedge clock);
        #1;
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_pixels", pix, 19200);
        chk("t4_busy_idle", int'(busy), 0);

        // new frame after done, reset in column 40
        clear_stats();
        start_pulse();
        chk("t5_busy", int'(busy), 1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(plot && x == 8'd40) && n < 30000);
        chk("t5_reach_col40", int'(plot && x == 8'd40), 1);
        chk("t5_order", order_err, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_plot", int'(plot), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_xyc", int'({x, y, colour}), 0);
        chk("abort_addr_done", int'({ram_addr, done}), 0);
        @(negedge clock);
        reset = 1'b1;
        p0 = pix;
        repeat (300) @(posedge clock);
        #1;
        chk("abort_no_plots", pix - p0, 0);
        chk("abort_no_done", done_cnt, 0);

        clear_stats();
        start_pulse();
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!plot && n < 1000);
        chk("restart_x", int'(x), 0);
        chk("restart_y", int'(y), 0);
`ifdef RENDER_SURFACE_EN
        chk("restart_colour", int'(colour), SURF);
`else
        chk("restart_colour", int'(colour), GND);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
